// File: rtl/soc_map_pkg.sv
// Shared SoC address map: MMIO decode bit, register offsets and STATUS layout.
package soc_map_pkg;

  localparam int unsigned MMIO_BASE_BIT = 31;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  // Bit in STATUS write data that clears the sticky overflow flag.
  localparam int unsigned ST_OVF_CLR_BIT = ST_OVF;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with occupancy count; head reads 0 while empty.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_c;
  logic          pop_ok_c;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push+pop while full is legal.
  assign pop_ok_c  = pop && !empty;
  assign push_ok_c = push && (!full || pop_ok_c);

  // Next-state for pointers and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: byte-lane word RAM plus CYCLE/TXDATA/STATUS MMIO.
module dmem_mmio_responder
  import soc_map_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [31:0]   cycle_q, cycle_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] idx_c;
  logic          is_mmio_c;
  logic [7:0]    off_c;
  logic          ram_we_c;
  logic          mmio_we_c;
  logic          push_c;
  logic          ovf_clr_c;
  logic          drop_c;
  logic          fifo_empty_c;
  logic          fifo_full_c;
  logic [CW-1:0] fifo_count_c;
  logic [31:0]   status_c;
  logic          unused_addr_c;

  assign idx_c     = daddr[AW+1:2];
  assign is_mmio_c = daddr[MMIO_BASE_BIT];
  assign off_c     = daddr[7:0];

  // Writes are suppressed in the reset cycle.
  assign ram_we_c  = reset && !is_mmio_c;
  assign mmio_we_c = reset && is_mmio_c && dwe[0];
  assign push_c    = mmio_we_c && (off_c == OFF_TXDATA);
  assign ovf_clr_c = mmio_we_c && (off_c == OFF_STATUS) && dwdata[ST_OVF_CLR_BIT];

  // Full implies non-empty, so a ready consumer always frees a slot.
  assign drop_c    = push_c && fifo_full_c && !tx_ready;

  // Address bits outside both decodes are intentionally ignored.
  assign unused_addr_c = ^{daddr[30:8], daddr[1:0]};

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_c),
    .push_data (dwdata[7:0]),
    .pop       (tx_ready),
    .head      (tx_data),
    .count     (fifo_count_c),
    .empty     (fifo_empty_c),
    .full      (fifo_full_c)
  );

  assign tx_valid = !fifo_empty_c;

  // Next-state for the cycle counter and sticky overflow; clear beats set.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ovf_d   = ovf_q;
    if (drop_c)    ovf_d = 1'b1;
    if (ovf_clr_c) ovf_d = 1'b0;
  end

  // Counter and overflow registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) mem_q[idx_c][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  // STATUS register image.
  always_comb begin
    status_c                      = '0;
    status_c[ST_EMPTY]            = fifo_empty_c;
    status_c[ST_FULL]             = fifo_full_c;
    status_c[ST_OVF]              = ovf_q;
    status_c[ST_COUNT_LSB +: 8]   = 8'(fifo_count_c);
  end

  // Same-cycle read mux; CYCLE reads 0 while reset is held.
  always_comb begin
    drdata = '0;
    if (!is_mmio_c) begin
      drdata = mem_q[idx_c];
    end else begin
      case (off_c)
        OFF_CYCLE:  drdata = reset ? cycle_q : 32'h0;
        OFF_STATUS: drdata = status_c;
        default:    drdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench: stimulus pushes expected per-cycle responses, monitor checks.
module tb_dmem_mmio_responder;

  localparam int unsigned MEM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic [31:0] drdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  dmem_mmio_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    bit          txv;
    bit          chk_txd;
    logic [7:0]  txd;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  // Reference model state: byte-addressed RAM, byte queue, counter, flag.
  logic [7:0]  ram_m [int];
  logic [7:0]  fq_m[$];
  logic [31:0] cyc_m   = '0;
  bit          ovf_m   = 1'b0;
  bit          fresh_m = 1'b1;

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = '0;
    s[0]    = (fq_m.size() == 0);
    s[1]    = (fq_m.size() == FIFO_DEPTH);
    s[2]    = ovf_m;
    s[15:8] = 8'(fq_m.size());
    return s;
  endfunction

  // Issue one core access; record what the DUT must show during this cycle,
  // then advance the model across the clock edge.
  task automatic step(input bit rst_n, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] w, input bit rdy);
    exp_t e;
    int   idx;
    bit   pop;
    logic [7:0] off;
    @(negedge clk);
    reset = rst_n; daddr = a; dwdata = wd; dwe = w; tx_ready = rdy;
    idx = int'((a >> 2) % MEM_WORDS);
    off = a[7:0];
    e.id = step_id++;
    e.chk_rd = 1'b1;
    e.rd = '0;
    if (!a[31]) begin
      for (int l = 0; l < 4; l++) begin
        if (!ram_m.exists(idx*4 + l)) e.chk_rd = 1'b0;
        else e.rd[8*l +: 8] = ram_m[idx*4 + l];
      end
    end else if (off == 8'h00) begin
      e.rd = rst_n ? cyc_m : 32'h0;
    end else if (off == 8'h08) begin
      e.rd = status_m();
    end
    e.txv     = (fq_m.size() != 0);
    e.chk_txd = e.txv || fresh_m;
    e.txd     = e.txv ? fq_m[0] : 8'h00;
    sb.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      cyc_m = '0; fq_m.delete(); ovf_m = 1'b0; fresh_m = 1'b1;
    end else begin
      cyc_m = cyc_m + 32'd1;
      pop = e.txv && rdy;
      if (pop) void'(fq_m.pop_front());
      if (!a[31]) begin
        for (int l = 0; l < 4; l++) if (w[l]) ram_m[idx*4 + l] = wd[8*l +: 8];
      end else if (w[0]) begin
        if (off == 8'h04) begin
          if (fq_m.size() < FIFO_DEPTH) begin
            fq_m.push_back(wd[7:0]); fresh_m = 1'b0;
          end else ovf_m = 1'b1;
        end else if (off == 8'h08 && wd[2]) begin
          ovf_m = 1'b0;
        end
      end
    end
  endtask

  // Monitor: settle after the drive edge, pop the expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.chk_rd) begin
        n_checks++;
        if (drdata !== e.rd) begin
          n_fail++;
          $display("FAIL drdata step=%0d addr=%h got=%h exp=%h", e.id, daddr, drdata, e.rd);
        end
      end
      n_checks++;
      if (tx_valid !== e.txv) begin
        n_fail++;
        $display("FAIL tx_valid step=%0d got=%b exp=%b", e.id, tx_valid, e.txv);
      end
      if (e.chk_txd) begin
        n_checks++;
        if (tx_data !== e.txd) begin
          n_fail++;
          $display("FAIL tx_data step=%0d got=%h exp=%h", e.id, tx_data, e.txd);
        end
      end
    end
  end

  localparam logic [31:0] A_CYC = 32'h8000_0000;
  localparam logic [31:0] A_TX  = 32'h8000_0004;
  localparam logic [31:0] A_ST  = 32'h8000_0008;

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          k;

    // Reset, including a write that must be ignored.
    step(0, A_CYC, 32'h0, 4'h0, 1'b0);
    step(0, A_TX,  32'h77, 4'h1, 1'b0);
    step(0, A_ST,  32'h0, 4'h0, 1'b0);

    // Counter out of reset.
    for (int i = 0; i < 6; i++) step(1, A_CYC, 32'h0, 4'h0, 1'b0);

    // Byte lanes and aliasing.
    step(1, 32'h10, 32'hAABB_CCDD, 4'hF, 1'b0);
    step(1, 32'h10, 32'h1122_3344, 4'b0101, 1'b0);
    step(1, 32'h10, 32'h0, 4'h0, 1'b0);
    step(1, 32'h10 + 4*MEM_WORDS, 32'h0, 4'h0, 1'b0);
    step(1, 32'h13, 32'hFFFF_FFFF, 4'h0, 1'b0);

    // Fill past full, then drain.
    for (int i = 1; i <= 9; i++) step(1, A_TX, 32'(i), 4'h1, 1'b0);
    step(1, A_ST, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1, A_ST, 32'h0, 4'h0, 1'b1);
    step(1, A_ST, 32'h0, 4'h0, 1'b1);

    // Clear OVF; a write without dwe[0] must not clear.
    step(1, A_ST, 32'h4, 4'hE, 1'b0);
    step(1, A_ST, 32'h4, 4'h1, 1'b0);
    step(1, A_ST, 32'h0, 4'h0, 1'b0);

    // Push while full with a concurrent pop.
    for (int i = 0; i < 8; i++) step(1, A_TX, 32'(8'h30 + i), 4'h1, 1'b0);
    step(1, A_TX, 32'h5A, 4'h1, 1'b1);
    step(1, A_ST, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 9; i++) step(1, A_ST, 32'h0, 4'h0, 1'b1);

    // Push+pop at count 1.
    step(1, A_TX, 32'hC1, 4'h1, 1'b0);
    step(1, A_TX, 32'hC2, 4'h1, 1'b1);
    step(1, A_ST, 32'h0, 4'h0, 1'b1);
    step(1, A_ST, 32'h0, 4'h0, 1'b0);

    // Mid-operation reset with RAM retention.
    step(1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) step(1, A_TX, 32'(8'hE0 + i), 4'h1, 1'b0);
    step(0, A_ST, 32'h0, 4'h0, 1'b1);
    step(1, A_ST, 32'h0, 4'h0, 1'b0);
    step(1, A_CYC, 32'h0, 4'h0, 1'b0);
    step(1, 32'h40, 32'h0, 4'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 5);
      w = 4'($urandom);
      case (k)
        0, 1: a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 15)) << 2)
                  | 32'($urandom_range(0, 3));
        2, 3: begin
          a = A_TX | ($urandom & 32'h7FFF_FF00);
          if ($urandom_range(0, 3) != 0) w[0] = 1'b1;
        end
        4: a = (($urandom_range(0, 1) != 0) ? A_ST : A_CYC) | ($urandom & 32'h7FFF_FF00);
        default: a = 32'h8000_0000 | $urandom;
      endcase
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, a, $urandom, w,
           ($urandom_range(0, 2) == 0));
    end

    step(1, A_ST, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the CPU data-memory port. It answers the `daddr`/`dwdata`/`dwe`/`drdata` accesses that the single-cycle core issues.
- Provides a byte-lane-writable word RAM.
- Provides a small MMIO region: a free-running cycle counter and a byte TX FIFO with a valid/ready drain port.
- Sits beside instruction memory in the top-level SoC. Reads are combinational because the core expects same-cycle load data. Writes commit at the clock edge.

Parameters:
- MEM_WORDS, 1024, number of 32-bit RAM words; must be a power of two.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, between 2 and 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- daddr  input  32  byte address from the core.
- dwdata  input  32  write data from the core.
- dwe  input  4  byte write enables; dwe[i] writes dwdata[8i+7:8i].
- drdata  output  32  combinational read data for daddr.
- tx_valid  output  1  FIFO head available.
- tx_data  output  8  FIFO head byte.
- tx_ready  input  1  consumer accepts the head this cycle.

Behaviour:
- Region decode:
  - daddr[31]=0 selects RAM. Word index is daddr[log2(MEM_WORDS)+1:2]; higher bits are ignored, so RAM aliases. daddr[1:0] is ignored, so accesses are word-aligned.
  - daddr[31]=1 selects MMIO. Offset is daddr[7:0]; bits [30:8] are ignored.
- RAM:
  - Read: drdata = mem[idx], combinational.
  - Write: on rising clk, each byte lane with dwe[i]=1 is updated. Lanes with dwe[i]=0 are untouched.
  - RAM is not cleared by reset. Contents are undefined until written.
  - A read of an address being written in the same cycle returns the old data.
- MMIO map (reads are combinational; writes need dwe[0]=1, and other dwe bits are ignored):
  - 0x00 CYCLE, read-only.
    - 32-bit counter; +1 every cycle out of reset; wraps from 0xFFFFFFFF to 0.
    - Reads 0 during the cycle reset is asserted.
  - 0x04 TXDATA.
    - A write pushes dwdata[7:0].
    - If the FIFO is full with no pop this cycle, the push is dropped and OVF sets. The FIFO is unchanged.
    - Reads return 0.
  - 0x08 STATUS, read value:
    - bit0 = empty.
    - bit1 = full.
    - bit2 = OVF (sticky).
    - bits[15:8] = count, zero-extended.
    - all other bits 0.
    - A write with dwdata[2]=1 clears OVF. If a dropped push and the clear occur together, the clear has priority.
  - Any other offset reads 0; writes to it are ignored.
- FIFO:
  - Circular buffer with write and read pointers and a count that spans 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
  - tx_valid = (count != 0). tx_data = head entry, stable while tx_valid=1 and tx_ready=0.
  - Pop occurs when tx_valid and tx_ready.
  - Simultaneous push and pop: both take effect and count is unchanged. This holds when full, so no overflow, and when count=1.
  - Push when empty: tx_valid rises the next cycle. There is no fall-through of the same-cycle write.
- Reset (reset=0 at a rising edge):
  - CYCLE=0, FIFO pointers and count = 0, OVF=0.
  - Resulting outputs: tx_valid=0, tx_data=0.
  - Any write presented in the reset cycle is ignored, both RAM and MMIO.
  - Reset asserted mid-drain discards all FIFO contents; the consumer must not rely on a handshake completing in that cycle.
- There is no backpressure to the core. Every access completes in one cycle.

Decomposition:
- Shared package `soc_map_pkg` holds:
  - MMIO_BASE_BIT (31).
  - Offsets OFF_CYCLE=8'h00, OFF_TXDATA=8'h04, OFF_STATUS=8'h08.
  - STATUS bit positions (ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=8).
- One sub-module `byte_fifo`, parameterised by depth, with a synchronous active-low reset.
  - Ports: push, push_data, pop, head, count, empty, full.
  - Reused later for an RX path.

Test Plan:
- Byte lanes: write 0xAABBCCDD to 0x10 with dwe=4'hF, then write 0x11223344 with dwe=4'b0101; read 0x10 -> 0xAA22CC44. Read 0x10+4*MEM_WORDS -> same value (aliasing).
- Cycle counter: release reset at cycle N; read 0x80000000 at N+5 -> 5. Force the counter to 0xFFFFFFFF -> reads 0 on the next cycle.
- FIFO fill/overflow: with tx_ready=0, push bytes 1..9 to 0x80000004 with FIFO_DEPTH=8.
  - STATUS -> 0x00000806 (count 8, full, OVF).
  - Drain with tx_ready=1 -> tx_data sequence 1..8, then tx_valid=0, STATUS=0x00000005.
- Simultaneous push/pop while full: FIFO full and tx_ready=1, push 0x5A -> count stays 8, OVF stays 0, 0x5A emerges last.
- OVF clear: with OVF set, write 0x4 to 0x80000008 -> STATUS bit2=0. Clear in the same cycle as a dropped push -> bit2=0.
- Mid-operation reset: FIFO holds 3 bytes and CYCLE=100; pulse reset=0 for one cycle -> tx_valid=0, STATUS=0x00000001, CYCLE restarts from 0. A RAM word written before reset still reads back unchanged.
